// File: rtl/dlsc_axi_router_addr_arb_pkg.sv
// Shared helpers for the AXI router: address-to-sink match and round-robin pick.
package dlsc_axi_router_addr_arb_pkg;

  // Widest address and widest requester set the helpers accept.
  localparam int unsigned ADDR_MAX = 64;
  localparam int unsigned RR_MAX   = 32;
  localparam int unsigned RR_IDXW  = 5;

  // True when addr falls in the window described by base/mask.
  function automatic logic addr_match(
    input logic [ADDR_MAX-1:0] addr,
    input logic [ADDR_MAX-1:0] base,
    input logic [ADDR_MAX-1:0] mask
  );
    return (addr & mask) == base;
  endfunction

  // First set bit of req at or after ptr, wrapping within n requesters.
  function automatic logic [RR_IDXW-1:0] rr_pick(
    input logic [RR_MAX-1:0]  req,
    input int unsigned        n,
    input logic [RR_IDXW-1:0] ptr
  );
    logic [RR_IDXW-1:0] win;
    logic               found;
    logic [RR_IDXW:0]   idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(RR_MAX); i++) begin
      idx = {1'b0, ptr} + (RR_IDXW+1)'(i);
      if (idx >= (RR_IDXW+1)'(n)) idx = idx - (RR_IDXW+1)'(n);
      if ((i < int'(n)) && !found && req[idx[RR_IDXW-1:0]]) begin
        win   = idx[RR_IDXW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dlsc_axi_router_addr_arb_rr.sv
// Round-robin arbiter: combinational grant from the pointer, pointer advances past each loaded winner.
module dlsc_axi_router_addr_arb_rr
  import dlsc_axi_router_addr_arb_pkg::*;
#(
  parameter int unsigned SOURCES  = 1,
  parameter int unsigned SOURCESB = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SOURCES-1:0]  req,
  input  logic                load,
  output logic [SOURCESB-1:0] grant_c,
  output logic                grant_valid_c
);

  logic [SOURCESB-1:0] ptr_q;
  logic [SOURCESB-1:0] ptr_d;

  // Winner is the first requester at or after the pointer.
  always_comb begin
    grant_c       = SOURCESB'(rr_pick(RR_MAX'(req), SOURCES, RR_IDXW'(ptr_q)));
    grant_valid_c = |req;
  end

  // Next pointer: one past the winner on load, otherwise unchanged.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      if (grant_c == SOURCESB'(SOURCES - 1)) ptr_d = '0;
      else                                    ptr_d = grant_c + SOURCESB'(1);
    end
  end

  // Pointer register; with a single source it can only ever hold 0.
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dlsc_axi_router_addr_arb.sv
// Address-channel arbiter/decoder: picks a master, decodes its sink, forwards the
// address and issues one {source, sink} command to the data-channel router.
module dlsc_axi_router_addr_arb
  import dlsc_axi_router_addr_arb_pkg::*;
#(
  parameter int unsigned             ADDR        = 32,
  parameter int unsigned             LEN         = 4,
  parameter int unsigned             SOURCES     = 1,
  parameter int unsigned             SOURCESB    = 1,
  parameter int unsigned             SINKS       = 1,
  parameter int unsigned             SINKSB      = 1,
  parameter logic [SINKS*ADDR-1:0]   BASES       = '0,
  parameter logic [SINKS*ADDR-1:0]   MASKS       = '0,
  parameter int unsigned             DECERR_SINK = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [SOURCES-1:0]      source_ready,
  input  logic [SOURCES-1:0]      source_valid,
  input  logic [SOURCES*ADDR-1:0] source_addr,
  input  logic [SOURCES*LEN-1:0]  source_len,
  input  logic [SINKS-1:0]        sink_ready,
  output logic [SINKS-1:0]        sink_valid,
  output logic [ADDR-1:0]         sink_addr,
  output logic [LEN-1:0]          sink_len,
  output logic [SOURCESB-1:0]     sink_source,
  input  logic                    cmd_full,
  output logic                    cmd_push,
  output logic [SOURCESB-1:0]     cmd_source,
  output logic [SINKSB-1:0]       cmd_sink
);

  logic [SOURCESB-1:0] win;
  logic                win_valid;
  logic [ADDR-1:0]     win_addr;
  logic [LEN-1:0]      win_len;
  logic [SINKSB-1:0]   win_sink;
  logic                win_found;

  logic                cmd_pending;
  logic                addr_pending;
  logic [ADDR-1:0]     hold_addr;
  logic [LEN-1:0]      hold_len;
  logic [SOURCESB-1:0] hold_src;
  logic [SINKSB-1:0]   hold_sink;

  logic                addr_go;
  logic                addr_hs;
  logic                push;
  logic                free;
  logic                load;

  dlsc_axi_router_addr_arb_rr #(
    .SOURCES  (SOURCES),
    .SOURCESB (SOURCESB)
  ) u_rr (
    .clk           (clk),
    .rst           (rst),
    .req           (source_valid),
    .load          (load),
    .grant_c       (win),
    .grant_valid_c (win_valid)
  );

  // Steer the winning source's address and length.
  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < int'(SOURCES); i++) begin
      if (win == SOURCESB'(i)) begin
        win_addr = source_addr[i*ADDR +: ADDR];
        win_len  = source_len[i*LEN +: LEN];
      end
    end
  end

  // Decode: lowest matching window wins, unmatched goes to the error sink.
  always_comb begin
    win_sink  = SINKSB'(DECERR_SINK);
    win_found = 1'b0;
    for (int k = 0; k < int'(SINKS); k++) begin
      if (!win_found && addr_match(ADDR_MAX'(win_addr),
                                   ADDR_MAX'(BASES[k*ADDR +: ADDR]),
                                   ADDR_MAX'(MASKS[k*ADDR +: ADDR]))) begin
        win_sink  = SINKSB'(k);
        win_found = 1'b1;
      end
    end
  end

  // Handshake control; the address never goes out ahead of its command.
  always_comb begin
    push    = cmd_pending && !cmd_full;
    addr_go = addr_pending && (!cmd_pending || !cmd_full);
    for (int k = 0; k < int'(SINKS); k++) begin
      sink_valid[k] = addr_go && (hold_sink == SINKSB'(k));
    end
    addr_hs = |(sink_valid & sink_ready);
    free    = (!cmd_pending || push) && (!addr_pending || addr_hs);
    load    = rst && win_valid && free;
    for (int i = 0; i < int'(SOURCES); i++) begin
      source_ready[i] = rst && win_valid && free && (win == SOURCESB'(i));
    end
  end

  assign cmd_push    = push;
  assign cmd_source  = hold_src;
  assign cmd_sink    = hold_sink;
  assign sink_source = hold_src;
  assign sink_addr   = hold_addr;
  assign sink_len    = hold_len;

  // Single-entry holding register with independent command/address flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_pending  <= 1'b0;
      addr_pending <= 1'b0;
      hold_addr    <= '0;
      hold_len     <= '0;
      hold_src     <= '0;
      hold_sink    <= '0;
    end else begin
      if (push)    cmd_pending  <= 1'b0;
      if (addr_hs) addr_pending <= 1'b0;
      if (load) begin
        cmd_pending  <= 1'b1;
        addr_pending <= 1'b1;
        hold_addr    <= win_addr;
        hold_len     <= win_len;
        hold_src     <= win;
        hold_sink    <= win_sink;
      end
    end
  end

endmodule

// File: tb/tb_dlsc_axi_router_addr_arb.sv
// Directed bench: a 3-source/3-sink router driven from a vector table, plus
// hand-written reset and single-source sequences.
module tb_dlsc_axi_router_addr_arb;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // 3 sources, 3 sinks; sink 2 is the error sink and never matches.
  logic [2:0]  source_ready, source_valid;
  logic [95:0] source_addr;
  logic [11:0] source_len;
  logic [2:0]  sink_ready, sink_valid;
  logic [31:0] sink_addr;
  logic [3:0]  sink_len;
  logic [1:0]  sink_source;
  logic        cmd_full, cmd_push;
  logic [1:0]  cmd_source, cmd_sink;

  dlsc_axi_router_addr_arb #(
    .ADDR        (32),
    .LEN         (4),
    .SOURCES     (3),
    .SOURCESB    (2),
    .SINKS       (3),
    .SINKSB      (2),
    .BASES       ({32'h0000_0001, 32'h8000_0000, 32'h0000_0000}),
    .MASKS       ({32'h0000_0000, 32'hC000_0000, 32'hC000_0000}),
    .DECERR_SINK (2)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .source_ready (source_ready),
    .source_valid (source_valid),
    .source_addr  (source_addr),
    .source_len   (source_len),
    .sink_ready   (sink_ready),
    .sink_valid   (sink_valid),
    .sink_addr    (sink_addr),
    .sink_len     (sink_len),
    .sink_source  (sink_source),
    .cmd_full     (cmd_full),
    .cmd_push     (cmd_push),
    .cmd_source   (cmd_source),
    .cmd_sink     (cmd_sink)
  );

  // Single source, two sinks split on address bit 31.
  logic        s1_ready, s1_valid;
  logic [31:0] s1_addr;
  logic [3:0]  s1_len;
  logic [1:0]  k1_ready, k1_valid;
  logic [31:0] k1_addr;
  logic [3:0]  k1_len;
  logic [0:0]  k1_source;
  logic        c1_full, c1_push;
  logic [0:0]  c1_source, c1_sink;

  dlsc_axi_router_addr_arb #(
    .ADDR        (32),
    .LEN         (4),
    .SOURCES     (1),
    .SOURCESB    (1),
    .SINKS       (2),
    .SINKSB      (1),
    .BASES       ({32'h8000_0000, 32'h0000_0000}),
    .MASKS       ({32'h8000_0000, 32'h8000_0000}),
    .DECERR_SINK (0)
  ) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .source_ready (s1_ready),
    .source_valid (s1_valid),
    .source_addr  (s1_addr),
    .source_len   (s1_len),
    .sink_ready   (k1_ready),
    .sink_valid   (k1_valid),
    .sink_addr    (k1_addr),
    .sink_len     (k1_len),
    .sink_source  (k1_source),
    .cmd_full     (c1_full),
    .cmd_push     (c1_push),
    .cmd_source   (c1_source),
    .cmd_sink     (c1_sink)
  );

  typedef struct {
    logic [2:0]  sv;
    logic        full;
    logic [2:0]  srdy;
    logic [2:0]  e_rdy;
    logic        e_push;
    logic [1:0]  e_src;
    logic [1:0]  e_sink;
    logic [2:0]  e_svalid;
    logic [31:0] e_addr;
    logic [3:0]  e_len;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [2:0] rdy, input logic push,
                            input logic [1:0] src, input logic [1:0] snk, input logic [2:0] sval,
                            input logic [31:0] addr, input logic [3:0] len);
    check({tag, " source_ready"}, 64'(source_ready), 64'(rdy));
    check({tag, " cmd_push"},     64'(cmd_push),     64'(push));
    check({tag, " cmd_source"},   64'(cmd_source),   64'(src));
    check({tag, " sink_source"},  64'(sink_source),  64'(src));
    check({tag, " cmd_sink"},     64'(cmd_sink),     64'(snk));
    check({tag, " sink_valid"},   64'(sink_valid),   64'(sval));
    check({tag, " sink_addr"},    64'(sink_addr),    64'(addr));
    check({tag, " sink_len"},     64'(sink_len),     64'(len));
  endtask

  initial begin
    // sv, full, srdy | ready, push, src, sink, sink_valid, addr, len
    vecs[0]  = '{3'b111, 1'b0, 3'b111, 3'b001, 1'b0, 2'd0, 2'd0, 3'b000, 32'h0000_0000, 4'd0};
    vecs[1]  = '{3'b111, 1'b0, 3'b111, 3'b010, 1'b1, 2'd0, 2'd0, 3'b001, 32'h0000_0100, 4'd1};
    vecs[2]  = '{3'b111, 1'b0, 3'b111, 3'b100, 1'b1, 2'd1, 2'd1, 3'b010, 32'h8000_0200, 4'd2};
    vecs[3]  = '{3'b111, 1'b0, 3'b111, 3'b001, 1'b1, 2'd2, 2'd2, 3'b100, 32'h4000_0300, 4'd3};
    vecs[4]  = '{3'b100, 1'b0, 3'b111, 3'b100, 1'b1, 2'd0, 2'd0, 3'b001, 32'h0000_0100, 4'd1};
    vecs[5]  = '{3'b000, 1'b0, 3'b111, 3'b000, 1'b1, 2'd2, 2'd2, 3'b100, 32'h4000_0300, 4'd3};
    vecs[6]  = '{3'b010, 1'b0, 3'b111, 3'b010, 1'b0, 2'd2, 2'd2, 3'b000, 32'h4000_0300, 4'd3};
    vecs[7]  = '{3'b000, 1'b1, 3'b111, 3'b000, 1'b0, 2'd1, 2'd1, 3'b000, 32'h8000_0200, 4'd2};
    vecs[8]  = '{3'b001, 1'b1, 3'b111, 3'b000, 1'b0, 2'd1, 2'd1, 3'b000, 32'h8000_0200, 4'd2};
    vecs[9]  = '{3'b001, 1'b1, 3'b111, 3'b000, 1'b0, 2'd1, 2'd1, 3'b000, 32'h8000_0200, 4'd2};
    vecs[10] = '{3'b001, 1'b0, 3'b111, 3'b001, 1'b1, 2'd1, 2'd1, 3'b010, 32'h8000_0200, 4'd2};
    vecs[11] = '{3'b000, 1'b0, 3'b110, 3'b000, 1'b1, 2'd0, 2'd0, 3'b001, 32'h0000_0100, 4'd1};
    vecs[12] = '{3'b100, 1'b1, 3'b110, 3'b000, 1'b0, 2'd0, 2'd0, 3'b001, 32'h0000_0100, 4'd1};
    vecs[13] = '{3'b100, 1'b0, 3'b110, 3'b000, 1'b0, 2'd0, 2'd0, 3'b001, 32'h0000_0100, 4'd1};
    vecs[14] = '{3'b100, 1'b0, 3'b111, 3'b100, 1'b0, 2'd0, 2'd0, 3'b001, 32'h0000_0100, 4'd1};
    vecs[15] = '{3'b000, 1'b0, 3'b111, 3'b000, 1'b1, 2'd2, 2'd2, 3'b100, 32'h4000_0300, 4'd3};
    vecs[16] = '{3'b000, 1'b0, 3'b111, 3'b000, 1'b0, 2'd2, 2'd2, 3'b000, 32'h4000_0300, 4'd3};

    rst          = 1'b0;
    source_valid = '0;
    source_addr  = {32'h4000_0300, 32'h8000_0200, 32'h0000_0100};
    source_len   = {4'd3, 4'd2, 4'd1};
    sink_ready   = '1;
    cmd_full     = 1'b0;
    s1_valid     = 1'b0;
    s1_addr      = '0;
    s1_len       = '0;
    k1_ready     = '1;
    c1_full      = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_main("reset", 3'b000, 1'b0, 2'd0, 2'd0, 3'b000, 32'h0, 4'd0);
    check("reset u1 push", 64'(c1_push), 64'd0);
    check("reset u1 valid", 64'(k1_valid), 64'd0);
    rst = 1'b1;

    // Arbitration, decode, cmd_full and sink backpressure from the table.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      source_valid = vecs[i].sv;
      cmd_full     = vecs[i].full;
      sink_ready   = vecs[i].srdy;
      #1;
      check_main($sformatf("row%0d", i), vecs[i].e_rdy, vecs[i].e_push, vecs[i].e_src,
                 vecs[i].e_sink, vecs[i].e_svalid, vecs[i].e_addr, vecs[i].e_len);
    end

    // Reset while a command is stuck behind cmd_full; pointer must return to 0.
    @(negedge clk);
    source_valid = 3'b001; cmd_full = 1'b0; sink_ready = 3'b111;
    #1;
    check("rst-seq accept src0", 64'(source_ready), 64'b001);
    @(negedge clk);
    source_valid = 3'b000; cmd_full = 1'b1;
    #1;
    check("rst-seq stalled push", 64'(cmd_push), 64'd0);
    check("rst-seq stalled valid", 64'(sink_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst-seq ready in reset", 64'(source_ready), 64'd0);
    @(negedge clk);
    #1;
    check_main("rst-seq after reset", 3'b000, 1'b0, 2'd0, 2'd0, 3'b000, 32'h0, 4'd0);
    rst = 1'b1; cmd_full = 1'b0; source_valid = 3'b011;
    #1;
    check("rst-seq ptr at 0", 64'(source_ready), 64'b001);
    check("rst-seq no stale push", 64'(cmd_push), 64'd0);
    @(negedge clk);
    source_valid = 3'b000;
    #1;
    check_main("rst-seq routed", 3'b000, 1'b1, 2'd0, 2'd0, 3'b001, 32'h0000_0100, 4'd1);

    // Single-source instance: bit-31 decode and back-to-back acceptance.
    @(negedge clk);
    s1_valid = 1'b1; s1_addr = 32'h8000_0010; s1_len = 4'd3;
    #1;
    check("u1 ready first", 64'(s1_ready), 64'd1);
    @(negedge clk);
    s1_addr = 32'h0000_0020; s1_len = 4'd5;
    #1;
    check("u1 push", 64'(c1_push), 64'd1);
    check("u1 cmd_sink", 64'(c1_sink), 64'd1);
    check("u1 cmd_source", 64'(c1_source), 64'd0);
    check("u1 sink_source", 64'(k1_source), 64'd0);
    check("u1 sink_valid", 64'(k1_valid), 64'b10);
    check("u1 sink_addr", 64'(k1_addr), 64'h8000_0010);
    check("u1 sink_len", 64'(k1_len), 64'd3);
    check("u1 ready second", 64'(s1_ready), 64'd1);
    @(negedge clk);
    s1_valid = 1'b0;
    #1;
    check("u1 push 2", 64'(c1_push), 64'd1);
    check("u1 cmd_sink 2", 64'(c1_sink), 64'd0);
    check("u1 sink_valid 2", 64'(k1_valid), 64'b01);
    check("u1 sink_addr 2", 64'(k1_addr), 64'h0000_0020);
    check("u1 sink_len 2", 64'(k1_len), 64'd5);
    @(negedge clk);
    #1;
    check("u1 idle push", 64'(c1_push), 64'd0);
    check("u1 idle valid", 64'(k1_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dlsc_axi_router_addr_arb.md
Name: dlsc_axi_router_addr_arb

Overview:
Upstream stage of the router data channel. Arbitrates AXI address requests (AW or AR) from SOURCES masters and decodes each address to a destination sink. Forwards the winning address to that sink and pushes exactly one {source, sink} command into the downstream channel's command port. One instance per address channel direction.

Parameters:
ADDR, 32, address width
LEN, 4, burst-length field width
SOURCES, 1, number of master-side address inputs
SOURCESB, 1, clog2(SOURCES), min 1
SINKS, 1, number of slave-side address outputs, including error sink
SINKSB, 1, clog2(SINKS), min 1
BASES, 0, SINKS*ADDR packed; sink k base in bits [k*ADDR+:ADDR]
MASKS, 0, SINKS*ADDR packed; sink k match mask
DECERR_SINK, 0, sink index used when no BASES/MASKS entry matches

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low (rst==0 resets on rising clk)
source_ready  out  SOURCES  per-source address ready
source_valid  in  SOURCES  per-source address valid
source_addr  in  SOURCES*ADDR  packed addresses
source_len  in  SOURCES*LEN  packed burst lengths
sink_ready  in  SINKS  per-sink address ready
sink_valid  out  SINKS  per-sink address valid; at most one bit set
sink_addr  out  ADDR  shared address bus
sink_len  out  LEN  shared length bus
sink_source  out  SOURCESB  originating source index, for ID extension
cmd_full  in  1  downstream command queue full
cmd_push  out  1  command push strobe
cmd_source  out  SOURCESB  command source index
cmd_sink  out  SINKSB  command sink index

Behaviour:
- Reset (rst==0): cmd_pending=0, addr_pending=0, rr pointer=0, held addr/len/src/sink=0. All outputs 0 in the cycle following reset. Reset mid-operation discards the held request; no push or valid is produced for it.
- Decode, combinational on the arbitration winner: sink = lowest k with (addr & MASKS[k]) == BASES[k]. If no k matches, sink = DECERR_SINK.
- Arbitration is round-robin:
  - Priority starts at the rr pointer and wraps.
  - Winner = first valid source at or after the pointer.
  - On load, the pointer becomes (winner+1) mod SOURCES.
  - The pointer is unchanged when nothing loads.
- Holding register, one entry, with two flags:
  - Load: sets cmd_pending=1 and addr_pending=1 and captures addr, len, src, sink.
  - cmd_push = cmd_pending && !cmd_full. cmd_pending clears on push.
  - sink_valid[sink] = addr_pending && (!cmd_pending || !cmd_full). The command is never pushed after the address handshake; a same-cycle push and handshake is legal. Once asserted, sink_valid holds until sink_ready.
  - addr_pending clears on sink_valid && sink_ready[sink].
- free = (!cmd_pending || cmd_push) && (!addr_pending || addr handshake).
  - source_ready[winner] = free. All other source_ready bits are 0.
  - Load occurs on source_valid[winner] && free. This is a combinational ready path from sink_ready/cmd_full; it is intentional.
- Latency: a source handshake in cycle N gives cmd_push and sink_valid at N+1 at the earliest.
- Throughput: 1 request/cycle when never stalled.
- cmd_full held high: sink_valid stays low and the register stays full, so no source is accepted.
- sink_source, sink_addr and sink_len are driven from the register and are stable while pending. cmd_source equals sink_source.
- SOURCES==1: arbitration degenerates and the pointer is constant 0.

Decomposition:
- Shared package: sink-index decode function and round-robin priority function. Both are reused by the R/W response-path routers.
- One natural sub-module: dlsc_axi_router_addr_arb_rr (SOURCES-wide round-robin arbiter with pointer state and a load enable).

Test Plan:
1. SOURCES=1, SINKS=2, BASES={0x0,0x8000_0000}, MASKS={0x8000_0000,0x8000_0000}. Source addr 0x8000_0010, len 3, valid at cycle 0 → cycle 1: cmd_push=1, cmd_sink=1, sink_valid=2'b10, sink_addr=0x8000_0010, sink_len=3.
2. SOURCES=3, all valid continuously, sinks always ready → grant order 0,1,2,0,1,2. One push per cycle, and cmd_source matches sink_source every time.
3. cmd_full=1 for cycles 1–4 after a load → cmd_push and sink_valid stay 0 and source_ready=0. At cycle 5: cmd_push=1 and sink_valid=1 in the same cycle.
4. sink_ready=0 for 3 cycles after push → exactly one cmd_push, sink_valid held with addr stable, no second push. Load of the next request happens in the handshake cycle.
5. Address matching no BASES/MASKS entry, DECERR_SINK=2 → cmd_sink=2, sink_valid=3'b100.
6. rst=0 asserted while cmd_pending=1 and cmd_full=1 → next cycle: all outputs 0. After rst=1, the source re-presents and the request is routed normally with the pointer at 0.
